// File: rtl/mdu_iter.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiplier, restoring divider,
// with req/ready handshake, kill, and single-cycle divide-by-zero / overflow results.
module mdu_iter #(
  parameter int XLEN    = 32,
  parameter int MUL_BPC = 2,
  parameter int DIV_BPC = 1,
  parameter int TAG_W   = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_i,
  input  logic [2:0]       funct3_i,
  input  logic [XLEN-1:0]  op1_i,
  input  logic [XLEN-1:0]  op2_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             kill_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             valid_o,
  output logic [XLEN-1:0]  result_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam int MUL_N = XLEN / MUL_BPC;
  localparam int DIV_N = XLEN / DIV_BPC;
  localparam int CW    = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e              state_q, state_d;
  logic [2:0]          f3_q, f3_d;
  logic [TAG_W-1:0]    tag_q, tag_d, rtag_q, rtag_d;
  logic                neg_q, neg_d, valid_q, valid_d;
  logic [2*XLEN-1:0]   acc_q, acc_d, mcand_q, mcand_d;
  logic [XLEN-1:0]     mplier_q, mplier_d, quo_q, quo_d, dvsr_q, dvsr_d;
  logic [XLEN:0]       rem_q, rem_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [XLEN-1:0]     result_q, result_d;

  logic                accept, is_div, sgn1, sgn2, div0, ovf;
  logic [XLEN-1:0]     mag1, mag2;
  logic [2*XLEN-1:0]   mul_acc, mul_mc, prod;
  logic [XLEN-1:0]     mul_mp, div_quo;
  logic [XLEN:0]       div_rem;

  assign ready_o  = ((state_q == IDLE) || (state_q == DONE)) && !rst_i;
  assign busy_o   = (state_q == CALC) || (state_q == FIX);
  assign valid_o  = valid_q;
  assign result_o = result_q;
  assign tag_o    = rtag_q;

  assign accept = req_i && ready_o && !kill_i;
  assign is_div = funct3_i[2];
  assign sgn1   = (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                  (funct3_i == 3'b100) || (funct3_i == 3'b110);
  assign sgn2   = (funct3_i == 3'b001) || (funct3_i == 3'b100) || (funct3_i == 3'b110);
  assign mag1   = (sgn1 && op1_i[XLEN-1]) ? -op1_i : op1_i;
  assign mag2   = (sgn2 && op2_i[XLEN-1]) ? -op2_i : op2_i;
  assign div0   = is_div && (op2_i == '0);
  assign ovf    = is_div && !funct3_i[0] && (op1_i == INT_MIN) && (op2_i == '1);

  // One CALC step: MUL_BPC partial products and DIV_BPC restoring quotient bits.
  always_comb begin
    mul_acc = acc_q;
    mul_mc  = mcand_q;
    mul_mp  = mplier_q;
    for (int i = 0; i < MUL_BPC; i++) begin
      if (mul_mp[0]) mul_acc = mul_acc + mul_mc;
      mul_mc = mul_mc << 1;
      mul_mp = mul_mp >> 1;
    end
    div_rem = rem_q;
    div_quo = quo_q;
    for (int i = 0; i < DIV_BPC; i++) begin
      div_rem = {div_rem[XLEN-1:0], div_quo[XLEN-1]};
      div_quo = {div_quo[XLEN-2:0], 1'b0};
      if (div_rem >= {1'b0, dvsr_q}) begin
        div_rem    = div_rem - {1'b0, dvsr_q};
        div_quo[0] = 1'b1;
      end
    end
  end

  // Sign fix is applied across the full double-width product, never per half.
  assign prod = neg_q ? -acc_q : acc_q;

  always_comb begin
    state_d  = state_q;
    f3_d     = f3_q;
    tag_d    = tag_q;
    rtag_d   = rtag_q;
    neg_d    = neg_q;
    valid_d  = 1'b0;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          f3_d     = funct3_i;
          tag_d    = tag_i;
          case (funct3_i)
            3'b001, 3'b100: neg_d = op1_i[XLEN-1] ^ op2_i[XLEN-1];
            3'b010, 3'b110: neg_d = op1_i[XLEN-1];
            default:        neg_d = 1'b0;
          endcase
          acc_d    = '0;
          mcand_d  = {{XLEN{1'b0}}, mag1};
          mplier_d = mag2;
          rem_d    = '0;
          quo_d    = mag1;
          dvsr_d   = mag2;
          cnt_d    = is_div ? CW'(DIV_N - 1) : CW'(MUL_N - 1);
          if (div0 || ovf) begin
            state_d  = DONE;
            valid_d  = 1'b1;
            rtag_d   = tag_i;
            if (div0) result_d = funct3_i[1] ? op1_i : '1;
            else      result_d = funct3_i[1] ? '0 : op1_i;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (kill_i) begin
          state_d = IDLE;
        end else begin
          acc_d    = mul_acc;
          mcand_d  = mul_mc;
          mplier_d = mul_mp;
          rem_d    = div_rem;
          quo_d    = div_quo;
          if (cnt_q == '0) state_d = FIX;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      FIX: begin
        if (kill_i) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
          valid_d = 1'b1;
          rtag_d  = tag_q;
          case (f3_q)
            3'b000:                 result_d = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: result_d = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         result_d = neg_q ? -quo_q : quo_q;
            default:                result_d = neg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      f3_q     <= '0;
      tag_q    <= '0;
      rtag_q   <= '0;
      neg_q    <= 1'b0;
      valid_q  <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      f3_q     <= f3_d;
      tag_q    <= tag_d;
      rtag_q   <= rtag_d;
      neg_q    <= neg_d;
      valid_q  <= valid_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter at default parameters (XLEN=32, MUL 18 / DIV 34 cycle latency).
module tb_mdu_iter;
  logic        clk = 1'b0, rst = 1'b1, req = 1'b0, kill = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] op1 = '0, op2 = '0;
  logic [4:0]  tag = '0;
  logic        ready, busy, valid;
  logic [31:0] result;
  logic [4:0]  tag_out;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  mdu_iter dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .funct3_i(funct3), .op1_i(op1), .op2_i(op2),
    .tag_i(tag), .kill_i(kill), .ready_o(ready), .busy_o(busy), .valid_o(valid),
    .result_o(result), .tag_o(tag_out)
  );

  // Drives one op, then measures cycles from accept edge to valid_o (timeout -> 200).
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] t, output int lat, output int bsy,
                       output logic [31:0] res, output logic [4:0] rt);
    int w = 0;
    @(negedge clk);
    funct3 = f; op1 = a; op2 = b; tag = t; req = 1'b1;
    while (!ready && w < 100) begin @(negedge clk); w++; end
    @(posedge clk);
    #1 req = 1'b0; op1 = 32'hDEADBEEF; op2 = 32'h0;
    lat = 0; bsy = 0; res = '0; rt = '0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (valid) begin res = result; rt = tag_out; break; end
      if (busy) bsy++;
    end
  endtask

  task automatic test_reset();
    #1;
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0b exp=0", ready); end
    total++; if (valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL reset_valid_busy got=%0b%0b exp=00", valid, busy); end
    total++; if (result !== 32'h0 || tag_out !== 5'h0) begin bad++; $display("FAIL reset_result got=%h/%h exp=0/0", result, tag_out); end
    @(negedge clk); rst = 1'b0; #1;
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%0b exp=1", ready); end
  endtask

  task automatic test_mul();
    int lat, bsy; logic [31:0] res; logic [4:0] rt;
    do_op(3'b000, 32'd7, 32'hFFFFFFFD, 5'd3, lat, bsy, res, rt);
    total++; if (res !== 32'hFFFFFFEB) begin bad++; $display("FAIL mul_result got=%h exp=ffffffeb", res); end
    total++; if (rt !== 5'd3) begin bad++; $display("FAIL mul_tag got=%0d exp=3", rt); end
    total++; if (lat !== 18) begin bad++; $display("FAIL mul_latency got=%0d exp=18", lat); end
    total++; if (bsy !== 17) begin bad++; $display("FAIL mul_busy got=%0d exp=17", bsy); end
  endtask

  task automatic test_mulh();
    logic [2:0] f [4]; logic [31:0] a [4], b [4], e [4];
    int lat, bsy; logic [31:0] res; logic [4:0] rt;
    f = '{3'b001, 3'b010, 3'b011, 3'b001};
    a = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
    b = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
    e = '{32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h40000000};
    for (int i = 0; i < 4; i++) begin
      do_op(f[i], a[i], b[i], 5'(i + 4), lat, bsy, res, rt);
      total++; if (res !== e[i] || lat !== 18) begin bad++; $display("FAIL mulh_%0d got=%h lat=%0d exp=%h lat=18", i, res, lat, e[i]); end
    end
  endtask

  task automatic test_div();
    logic [2:0] f [4]; logic [31:0] a [4], b [4], e [4];
    int lat, bsy; logic [31:0] res; logic [4:0] rt;
    f = '{3'b100, 3'b110, 3'b101, 3'b111};
    a = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
    b = '{32'd2, 32'd2, 32'd7, 32'd7};
    e = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
    for (int i = 0; i < 4; i++) begin
      do_op(f[i], a[i], b[i], 5'(i + 10), lat, bsy, res, rt);
      total++; if (res !== e[i] || lat !== 34 || rt !== 5'(i + 10)) begin bad++; $display("FAIL div_%0d got=%h lat=%0d tag=%0d exp=%h lat=34 tag=%0d", i, res, lat, rt, e[i], i + 10); end
    end
  endtask

  task automatic test_fast_path();
    logic [2:0] f [4]; logic [31:0] a [4], b [4], e [4];
    int lat, bsy; logic [31:0] res; logic [4:0] rt;
    f = '{3'b101, 3'b111, 3'b100, 3'b110};
    a = '{32'h1234, 32'h1234, 32'h80000000, 32'h80000000};
    b = '{32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    e = '{32'hFFFFFFFF, 32'h1234, 32'h80000000, 32'h0};
    for (int i = 0; i < 4; i++) begin
      do_op(f[i], a[i], b[i], 5'(i + 20), lat, bsy, res, rt);
      total++; if (res !== e[i] || lat !== 1 || bsy !== 0) begin bad++; $display("FAIL fast_%0d got=%h lat=%0d busy=%0d exp=%h lat=1 busy=0", i, res, lat, bsy, e[i]); end
    end
  endtask

  task automatic test_kill();
    int lat, bsy, nv; logic [31:0] res; logic [4:0] rt;
    @(negedge clk);
    funct3 = 3'b100; op1 = 32'd1000; op2 = 32'd3; tag = 5'd7; req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    repeat (5) @(negedge clk);
    kill = 1'b1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL kill_busy_before got=%0b exp=1", busy); end
    @(posedge clk);
    #1 kill = 1'b0;
    @(negedge clk);
    total++; if (ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL kill_ready got=%0b busy=%0b exp=1/0", ready, busy); end
    nv = 0;
    repeat (40) begin @(negedge clk); if (valid) nv++; end
    total++; if (nv !== 0) begin bad++; $display("FAIL kill_no_valid got=%0d exp=0", nv); end
    do_op(3'b011, 32'd3, 32'd5, 5'd8, lat, bsy, res, rt);
    total++; if (res !== 32'h0 || lat !== 18 || rt !== 5'd8) begin bad++; $display("FAIL kill_then_mulhu got=%h lat=%0d tag=%0d exp=0 lat=18 tag=8", res, lat, rt); end
  endtask

  task automatic test_back_to_back();
    int n = 0, t1 = 0, t2 = 0, c = 0;
    logic [31:0] r1 = '0, r2 = '0; logic [4:0] g2 = '0;
    @(negedge clk);
    funct3 = 3'b000; op1 = 32'd11; op2 = 32'd13; tag = 5'd1; req = 1'b1;
    @(posedge clk);
    #1 funct3 = 3'b000; op1 = 32'd6; op2 = 32'd7; tag = 5'd9;
    while (n < 2 && c < 100) begin
      @(negedge clk);
      c++;
      if (valid) begin
        if (n == 0) begin t1 = c; r1 = result; end
        else begin t2 = c; r2 = result; g2 = tag_out; end
        n++;
        if (n == 1) begin @(posedge clk); #1 req = 1'b0; end
      end
    end
    req = 1'b0;
    total++; if (t1 !== 18 || r1 !== 32'd143) begin bad++; $display("FAIL b2b_first got=%0d/%h exp=18/0000008f", t1, r1); end
    total++; if (t2 !== 36 || r2 !== 32'd42 || g2 !== 5'd9) begin bad++; $display("FAIL b2b_second got=%0d/%h/%0d exp=36/0000002a/9", t2, r2, g2); end
  endtask

  task automatic test_reset_mid();
    int nv = 0;
    @(negedge clk);
    funct3 = 3'b000; op1 = 32'd5; op2 = 32'd5; tag = 5'd2; req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (valid !== 1'b0 || result !== 32'h0 || tag_out !== 5'h0) begin bad++; $display("FAIL rstmid_clear got=%0b/%h/%0d exp=0/0/0", valid, result, tag_out); end
    total++; if (busy !== 1'b0 || ready !== 1'b0) begin bad++; $display("FAIL rstmid_state got=busy%0b ready%0b exp=busy0 ready0", busy, ready); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%0b exp=1", ready); end
    repeat (25) begin @(negedge clk); if (valid) nv++; end
    total++; if (nv !== 0) begin bad++; $display("FAIL rstmid_no_valid got=%0d exp=0", nv); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_fast_path();
    test_kill();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
